// File: rtl/data_memory_pkg.sv
// Shared types and constants for the byte-addressable big-endian data memory.
package data_memory_pkg;
  localparam int DEPTH_BYTES_DEF = 128;
  localparam int BYTES_PER_WORD  = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/data_memory.sv
// Big-endian byte-addressable data memory: combinational 32-bit read, clocked 32-bit write.
// Define DATAMEM_ALIGN_EN to force word-aligned accesses (address bits [1:0] ignored).
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RW,
  input  logic [31:0] DAddr,
  input  logic [31:0] Datain,
  output logic [31:0] DataOut
);
  localparam int AW = $clog2(DEPTH_BYTES);

  byte_t                                mem [DEPTH_BYTES];
  logic  [AW-1:0]                       a;
  logic  [BYTES_PER_WORD-1:0][AW-1:0]   idx;
  logic                                 unused_addr;

`ifdef DATAMEM_ALIGN_EN
  assign a = {DAddr[AW-1:2], 2'b00};
`else
  assign a = DAddr[AW-1:0];
`endif

  // Upper address bits alias; they are intentionally dropped.
  assign unused_addr = ^{DAddr[31:AW], DAddr[1:0]};

  // Lane i addresses byte a+i; AW-bit addition gives the modulo-depth wrap for free.
  always_comb begin
    idx = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      idx[i] = a + AW'(i);
  end

  always_comb begin
    DataOut = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      DataOut[8*(BYTES_PER_WORD-1-i) +: 8] = mem[idx[i]];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int j = 0; j < DEPTH_BYTES; j++)
        mem[j] <= '0;
    end else if (RW) begin
      for (int i = 0; i < BYTES_PER_WORD; i++)
        mem[idx[i]] <= Datain[8*(BYTES_PER_WORD-1-i) +: 8];
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH_BYTES=128).
module tb_data_memory;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RW = 1'b0;
  logic [31:0] DAddr = '0;
  logic [31:0] Datain = '0;
  logic [31:0] DataOut;

  int checks = 0;
  int errors = 0;

  data_memory #(.DEPTH_BYTES(128)) dut (
    .CLK(CLK), .RST(RST), .RW(RW), .DAddr(DAddr), .Datain(Datain), .DataOut(DataOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (DataOut === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, DataOut, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    RW = 1'b1; DAddr = addr; Datain = data;
    @(posedge CLK); #1;
    RW = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    DAddr = addr; #1;
    check(tag, exp);
  endtask

  initial begin
    // reset with read request pending; no write after release
    #1 RST = 1'b0; RW = 1'b0; DAddr = 32'd1; Datain = 32'h0000ffff;
    #1 check("reset_out", 32'h0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_edge", 32'h0);
    rd(32'd0, 32'h0, "post_reset_a0");

    // same-cycle read/write: old contents before the edge, new after
    RW = 1'b1; DAddr = 32'd0; Datain = 32'h12345678; #1;
    check("pre_edge_old", 32'h0);
    @(posedge CLK); #1; RW = 1'b0;
    check("post_edge_new", 32'h12345678);

    // RW=0 ignores Datain
    Datain = 32'hffffffff;
    @(posedge CLK); #1;
    check("read_only_no_write", 32'h12345678);

`ifndef DATAMEM_ALIGN_EN
    rd(32'd1, 32'h34567800, "unaligned_rd1");
    rd(32'd3, 32'h78000000, "unaligned_rd3");

    // wrap across top of array
    wr(32'd126, 32'hAABBCCDD);
    rd(32'd126, 32'hAABBCCDD, "wrap_rd126");
    rd(32'd0,   32'hCCDD5678, "wrap_rd0");
    rd(32'd124, 32'h0000AABB, "wrap_rd124");
    rd(32'd127, 32'hBBCCDD56, "wrap_rd127");

    // aliasing of upper address bits
    wr(32'h80, 32'hCAFEBABE);
    rd(32'd0,          32'hCAFEBABE, "alias_rd0");
    rd(32'hFFFFFF80,   32'hCAFEBABE, "alias_rd_hi");
    rd(32'd126,        32'hAABBCAFE, "alias_rd126");

    // overlapping writes: later wins on shared bytes
    wr(32'd8,  32'h11111111);
    wr(32'd10, 32'h22222222);
    rd(32'd8,  32'h11112222, "overlap_rd8");
    rd(32'd12, 32'h22220000, "overlap_rd12");
`else
    // aligned mode: low address bits ignored on both write and read
    wr(32'd5, 32'h11223344);
    rd(32'd4, 32'h11223344, "align_rd4");
    rd(32'd7, 32'h11223344, "align_rd7");
    rd(32'd1, 32'h12345678, "align_rd1");
    wr(32'h82, 32'hCAFEBABE);
    rd(32'd0, 32'hCAFEBABE, "align_alias_rd0");
    rd(32'd8, 32'h0, "align_rd8_empty");
`endif

    // reset between edges with a write held: immediate clear, no writes while low
    RW = 1'b1; DAddr = 32'd0; Datain = 32'hDEADBEEF;
    @(negedge CLK); #2;
    RST = 1'b0; #1;
    check("mid_reset_immediate", 32'h0);
    @(posedge CLK); #1;
    check("mid_reset_edge1", 32'h0);
    @(posedge CLK); #1;
    check("mid_reset_edge2", 32'h0);
    DAddr = 32'd4; #1;
    check("mid_reset_a4", 32'h0);
    RW = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    rd(32'd0, 32'h0, "after_reset_a0");

    // post-reset write works again
    wr(32'd16, 32'h0BADF00D);
    rd(32'd16, 32'h0BADF00D, "post_reset_write");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
